// File: rtl/l1_trig_wb_intercon.sv
// l1_trig_wb_intercon: Wishbone B4 classic single-master, four-slave interconnect for the
// L1 trigger register space (threshold, generator/control, AGC, biquad; 8 KiB each).
// Accesses made while the downstream interface clock is stopped are acked locally.
// Optional build macro L1_INTERCON_TIMEOUT_EN: when defined, an ACTIVE transaction
// that sees no slave response for 255 cycles is terminated with wb_err_o.
module l1_trig_wb_intercon (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        clock_enabled_i,
    // upstream master port
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [14:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o,
    output logic [31:0] wb_dat_o,
    // threshold slave
    output logic        thresh_cyc_o,
    output logic        thresh_stb_o,
    output logic        thresh_we_o,
    output logic [12:0] thresh_adr_o,
    output logic [31:0] thresh_dat_o,
    output logic [3:0]  thresh_sel_o,
    input  logic        thresh_ack_i,
    input  logic        thresh_err_i,
    input  logic        thresh_rty_i,
    input  logic [31:0] thresh_dat_i,
    // generator/control slave
    output logic        control_cyc_o,
    output logic        control_stb_o,
    output logic        control_we_o,
    output logic [12:0] control_adr_o,
    output logic [31:0] control_dat_o,
    output logic [3:0]  control_sel_o,
    input  logic        control_ack_i,
    input  logic        control_err_i,
    input  logic        control_rty_i,
    input  logic [31:0] control_dat_i,
    // AGC slave
    output logic        agc_cyc_o,
    output logic        agc_stb_o,
    output logic        agc_we_o,
    output logic [12:0] agc_adr_o,
    output logic [31:0] agc_dat_o,
    output logic [3:0]  agc_sel_o,
    input  logic        agc_ack_i,
    input  logic        agc_err_i,
    input  logic        agc_rty_i,
    input  logic [31:0] agc_dat_i,
    // biquad slave
    output logic        bq_cyc_o,
    output logic        bq_stb_o,
    output logic        bq_we_o,
    output logic [12:0] bq_adr_o,
    output logic [31:0] bq_dat_o,
    output logic [3:0]  bq_sel_o,
    input  logic        bq_ack_i,
    input  logic        bq_err_i,
    input  logic        bq_rty_i,
    input  logic [31:0] bq_dat_i
);

    typedef enum logic [1:0] {StIdle, StActive, StGated, StResp} state_e;

    state_e      state_q;
    logic [1:0]  slv_q;     // latched slave index (wb_adr_i[14:13])
    logic [3:0]  ds_stb_q;  // one-hot downstream cyc/stb
    logic        ds_we_q;
    logic [12:0] ds_adr_q;
    logic [31:0] ds_dat_q;
    logic [3:0]  ds_sel_q;
    logic        ack_q;
    logic        err_q;
    logic        rty_q;
    logic [31:0] rdat_q;
`ifdef L1_INTERCON_TIMEOUT_EN
    logic [7:0]  tmo_q;
`endif

    logic        s_ack;
    logic        s_err;
    logic        s_rty;
    logic [31:0] s_dat;

    // Select the response lines of the slave owning the current transaction.
    always_comb begin
        s_ack = 1'b0;
        s_err = 1'b0;
        s_rty = 1'b0;
        s_dat = 32'h0;
        unique case (slv_q)
            2'd0: begin s_ack = thresh_ack_i;  s_err = thresh_err_i;  s_rty = thresh_rty_i;  s_dat = thresh_dat_i;  end
            2'd1: begin s_ack = control_ack_i; s_err = control_err_i; s_rty = control_rty_i; s_dat = control_dat_i; end
            2'd2: begin s_ack = agc_ack_i;     s_err = agc_err_i;     s_rty = agc_rty_i;     s_dat = agc_dat_i;     end
            2'd3: begin s_ack = bq_ack_i;      s_err = bq_err_i;      s_rty = bq_rty_i;      s_dat = bq_dat_i;      end
            default: ;
        endcase
    end

    // Transaction FSM with all bus outputs registered.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= StIdle;
            slv_q    <= 2'd0;
            ds_stb_q <= 4'h0;
            ds_we_q  <= 1'b0;
            ds_adr_q <= 13'h0;
            ds_dat_q <= 32'h0;
            ds_sel_q <= 4'h0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rty_q    <= 1'b0;
            rdat_q   <= 32'h0;
`ifdef L1_INTERCON_TIMEOUT_EN
            tmo_q    <= 8'h0;
`endif
        end else begin
            // Response strobes are single-cycle pulses by default.
            ack_q <= 1'b0;
            err_q <= 1'b0;
            rty_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (wb_cyc_i && wb_stb_i) begin
                        slv_q    <= wb_adr_i[14:13];
                        ds_we_q  <= wb_we_i;
                        ds_adr_q <= wb_adr_i[12:0];
                        ds_dat_q <= wb_dat_i;
                        ds_sel_q <= wb_sel_i;
`ifdef L1_INTERCON_TIMEOUT_EN
                        tmo_q    <= 8'h0;
`endif
                        if (clock_enabled_i) begin
                            ds_stb_q <= 4'b0001 << wb_adr_i[14:13];
                            state_q  <= StActive;
                        end else begin
                            state_q  <= StGated;
                        end
                    end
                end
                StActive: begin
                    if (!wb_cyc_i) begin
                        // Master gave up: release the slave, no upstream response.
                        ds_stb_q <= 4'h0;
                        state_q  <= StIdle;
                    end else if (s_err || s_rty || s_ack) begin
                        ds_stb_q <= 4'h0;
                        err_q    <= s_err;
                        rty_q    <= !s_err && s_rty;
                        ack_q    <= !s_err && !s_rty;
                        rdat_q   <= (s_err || s_rty) ? 32'h0 : s_dat;
                        state_q  <= StResp;
`ifdef L1_INTERCON_TIMEOUT_EN
                    end else if (tmo_q == 8'hff) begin
                        ds_stb_q <= 4'h0;
                        err_q    <= 1'b1;
                        rdat_q   <= 32'h0;
                        state_q  <= StResp;
                    end else begin
                        tmo_q    <= tmo_q + 8'd1;
`endif
                    end
                end
                StGated: begin
                    // Interface clock stopped: drop writes, read back zero.
                    ack_q   <= 1'b1;
                    rdat_q  <= 32'h0;
                    state_q <= StResp;
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_rty_o = rty_q;
    assign wb_dat_o = rdat_q;

    assign thresh_cyc_o  = ds_stb_q[0];
    assign thresh_stb_o  = ds_stb_q[0];
    assign control_cyc_o = ds_stb_q[1];
    assign control_stb_o = ds_stb_q[1];
    assign agc_cyc_o     = ds_stb_q[2];
    assign agc_stb_o     = ds_stb_q[2];
    assign bq_cyc_o      = ds_stb_q[3];
    assign bq_stb_o      = ds_stb_q[3];

    assign thresh_we_o   = ds_we_q;
    assign control_we_o  = ds_we_q;
    assign agc_we_o      = ds_we_q;
    assign bq_we_o       = ds_we_q;
    assign thresh_adr_o  = ds_adr_q;
    assign control_adr_o = ds_adr_q;
    assign agc_adr_o     = ds_adr_q;
    assign bq_adr_o      = ds_adr_q;
    assign thresh_dat_o  = ds_dat_q;
    assign control_dat_o = ds_dat_q;
    assign agc_dat_o     = ds_dat_q;
    assign bq_dat_o      = ds_dat_q;
    assign thresh_sel_o  = ds_sel_q;
    assign control_sel_o = ds_sel_q;
    assign agc_sel_o     = ds_sel_q;
    assign bq_sel_o      = ds_sel_q;

endmodule

// File: tb/tb_l1_trig_wb_intercon.sv
// Testbench for l1_trig_wb_intercon: table of directed transactions, randomized
// transactions against a behavioural model, and hand-written abort/reset/back-to-back
// sequences. Honours L1_INTERCON_TIMEOUT_EN for the watchdog vectors.
module tb_l1_trig_wb_intercon;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        wb_cyc, wb_stb, wb_we;
    logic [14:0] wb_adr;
    logic [31:0] wb_wdat;
    logic [3:0]  wb_sel;
    logic        wb_ack, wb_err, wb_rty;
    logic [31:0] wb_rdat;

    // Index 0 thresh, 1 control, 2 agc, 3 bq.
    logic [3:0]  ds_cyc, ds_stb, ds_we;
    logic [12:0] ds_adr [4];
    logic [31:0] ds_dat [4];
    logic [3:0]  ds_sel [4];
    logic [3:0]  s_ack, s_err, s_rty;
    logic [31:0] s_rdat [4];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    l1_trig_wb_intercon dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .clock_enabled_i(ce),
        .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we), .wb_adr_i(wb_adr),
        .wb_dat_i(wb_wdat), .wb_sel_i(wb_sel),
        .wb_ack_o(wb_ack), .wb_err_o(wb_err), .wb_rty_o(wb_rty), .wb_dat_o(wb_rdat),
        .thresh_cyc_o(ds_cyc[0]), .thresh_stb_o(ds_stb[0]), .thresh_we_o(ds_we[0]),
        .thresh_adr_o(ds_adr[0]), .thresh_dat_o(ds_dat[0]), .thresh_sel_o(ds_sel[0]),
        .thresh_ack_i(s_ack[0]), .thresh_err_i(s_err[0]), .thresh_rty_i(s_rty[0]),
        .thresh_dat_i(s_rdat[0]),
        .control_cyc_o(ds_cyc[1]), .control_stb_o(ds_stb[1]), .control_we_o(ds_we[1]),
        .control_adr_o(ds_adr[1]), .control_dat_o(ds_dat[1]), .control_sel_o(ds_sel[1]),
        .control_ack_i(s_ack[1]), .control_err_i(s_err[1]), .control_rty_i(s_rty[1]),
        .control_dat_i(s_rdat[1]),
        .agc_cyc_o(ds_cyc[2]), .agc_stb_o(ds_stb[2]), .agc_we_o(ds_we[2]),
        .agc_adr_o(ds_adr[2]), .agc_dat_o(ds_dat[2]), .agc_sel_o(ds_sel[2]),
        .agc_ack_i(s_ack[2]), .agc_err_i(s_err[2]), .agc_rty_i(s_rty[2]),
        .agc_dat_i(s_rdat[2]),
        .bq_cyc_o(ds_cyc[3]), .bq_stb_o(ds_stb[3]), .bq_we_o(ds_we[3]),
        .bq_adr_o(ds_adr[3]), .bq_dat_o(ds_dat[3]), .bq_sel_o(ds_sel[3]),
        .bq_ack_i(s_ack[3]), .bq_err_i(s_err[3]), .bq_rty_i(s_rty[3]),
        .bq_dat_i(s_rdat[3])
    );

    // Stimulus and expectation record. mask = {err, rty, ack} raised by the slave
    // dly cycles after its stb first rises. Codes: 0 ack, 1 err, 2 rty.
    typedef struct {
        logic [14:0] adr;
        logic        we;
        logic [31:0] wdat;
        logic [3:0]  sel;
        logic        ce;
        int          dly;
        logic [2:0]  mask;
        logic [31:0] rdata;
        int          e_lat;
        int          e_code;
        logic [31:0] e_rd;
        int          e_stb;
        logic [12:0] e_dadr;
    } vec_t;

    typedef struct {
        int          lat;
        int          code;   // 3 = no response, 4 = multiple responses
        logic [31:0] rd;
        int          n_resp;
        int          bad_stb;
        int          stb_cyc;
        logic [12:0] dadr;
        logic        dwe;
        logic [31:0] ddat;
        logic [3:0]  dsel;
    } res_t;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic vec_t mk(logic [14:0] adr, logic we, logic [31:0] wdat, logic [3:0] sel,
                                logic c, int dly, logic [2:0] mask, logic [31:0] rdata,
                                int e_lat, int e_code, logic [31:0] e_rd, int e_stb,
                                logic [12:0] e_dadr);
        vec_t v;
        v.adr = adr; v.we = we; v.wdat = wdat; v.sel = sel; v.ce = c; v.dly = dly;
        v.mask = mask; v.rdata = rdata; v.e_lat = e_lat; v.e_code = e_code;
        v.e_rd = e_rd; v.e_stb = e_stb; v.e_dadr = e_dadr;
        return v;
    endfunction

    // Behavioural reference: what the bus should see for one transaction.
    function automatic vec_t model(vec_t v);
        vec_t m = v;
        m.e_dadr = 13'(int'(v.adr) % 8192);
        if (!v.ce) begin
            m.e_lat = 2; m.e_code = 0; m.e_rd = 32'h0; m.e_stb = 0;
        end else begin
            m.e_lat  = v.dly + 2;
            m.e_stb  = v.dly + 1;
            m.e_code = v.mask[2] ? 1 : (v.mask[1] ? 2 : 0);
            m.e_rd   = (m.e_code == 0) ? v.rdata : 32'h0;
        end
        return m;
    endfunction

    function automatic int out_nonzero();
        int n = 0;
        n += int'(wb_ack) + int'(wb_err) + int'(wb_rty) + int'(wb_rdat != 0);
        n += int'(ds_cyc != 0) + int'(ds_stb != 0) + int'(ds_we != 0);
        for (int s = 0; s < 4; s++)
            n += int'(ds_adr[s] != 0) + int'(ds_dat[s] != 0) + int'(ds_sel[s] != 0);
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_xfer(input vec_t v, output res_t r);
        int  tgt;
        int  since;
        bit  driven;
        tgt = int'(v.adr) / 8192;
        r.lat = 0; r.code = 3; r.rd = 0; r.n_resp = 0; r.bad_stb = 0; r.stb_cyc = 0;
        r.dadr = 0; r.dwe = 0; r.ddat = 0; r.dsel = 0;
        for (int s = 0; s < 4; s++) s_rdat[s] = (s == tgt) ? v.rdata : $urandom;
        wb_adr = v.adr; wb_we = v.we; wb_wdat = v.wdat; wb_sel = v.sel;
        ce = v.ce; wb_cyc = 1'b1; wb_stb = 1'b1;
        since = -1;
        driven = 1'b0;
        for (int c = 1; c <= 300 && r.code == 3; c++) begin
            tick();
            s_ack = '0; s_err = '0; s_rty = '0;
            ce = 1'($urandom);  // must be ignored once the request is taken
            for (int s = 0; s < 4; s++)
                if ((ds_cyc[s] || ds_stb[s]) && (s != tgt || !v.ce)) r.bad_stb++;
            if (ds_stb[tgt]) begin
                r.stb_cyc++;
                since++;
                if (since == 0) begin
                    r.dadr = ds_adr[tgt]; r.dwe = ds_we[tgt];
                    r.ddat = ds_dat[tgt]; r.dsel = ds_sel[tgt];
                end
            end
            if (wb_ack || wb_err || wb_rty) begin
                r.n_resp++;
                r.lat  = c;
                r.code = ($countones({wb_ack, wb_err, wb_rty}) > 1) ? 4 :
                         wb_err ? 1 : (wb_rty ? 2 : 0);
                r.rd   = wb_rdat;
                wb_cyc = 1'b0; wb_stb = 1'b0;
            end else if (since == v.dly && !driven) begin
                {s_err[tgt], s_rty[tgt], s_ack[tgt]} = v.mask;
                driven = 1'b1;
            end
        end
        wb_cyc = 1'b0; wb_stb = 1'b0;
        s_ack = '0; s_err = '0; s_rty = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (wb_ack || wb_err || wb_rty) r.n_resp++;
            if (ds_stb != 0 || ds_cyc != 0) r.bad_stb++;
        end
    endtask

    task automatic check_xfer(string tag, vec_t v, res_t r);
        check($sformatf("%s_latency", tag), r.lat, v.e_lat);
        check($sformatf("%s_resp_kind", tag), r.code, v.e_code);
        if (v.e_code == 0) check($sformatf("%s_rdata", tag), r.rd, v.e_rd);
        check($sformatf("%s_resp_count", tag), r.n_resp, 1);
        check($sformatf("%s_stray_stb", tag), r.bad_stb, 0);
        check($sformatf("%s_stb_cycles", tag), r.stb_cyc, v.e_stb);
        if (v.ce) begin
            check($sformatf("%s_ds_adr", tag), r.dadr, v.e_dadr);
            check($sformatf("%s_ds_we", tag), r.dwe, v.we);
            if (v.we) begin
                check($sformatf("%s_ds_dat", tag), r.ddat, v.wdat);
                check($sformatf("%s_ds_sel", tag), r.dsel, v.sel);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        vec_t v;
        res_t r;
        int   nr;

        tbl.push_back(mk(15'h4010, 0, 32'h0, 4'hF, 1, 3, 3'b001, 32'hA5A5_0001,
                         5, 0, 32'hA5A5_0001, 4, 13'h0010));
        tbl.push_back(mk(15'h2004, 1, 32'h1234_5678, 4'hF, 1, 0, 3'b001, 32'h0BAD_0BAD,
                         2, 0, 32'h0BAD_0BAD, 1, 13'h0004));
        tbl.push_back(mk(15'h0100, 1, 32'hCAFE_F00D, 4'h3, 0, 0, 3'b001, 32'hFFFF_FFFF,
                         2, 0, 32'h0, 0, 13'h0100));
        tbl.push_back(mk(15'h0100, 0, 32'h0, 4'hF, 0, 0, 3'b001, 32'hFFFF_FFFF,
                         2, 0, 32'h0, 0, 13'h0100));
        tbl.push_back(mk(15'h6000, 0, 32'h0, 4'hF, 1, 1, 3'b101, 32'h5555_AAAA,
                         3, 1, 32'h0, 2, 13'h0000));
        tbl.push_back(mk(15'h1FFF, 0, 32'h0, 4'hF, 1, 2, 3'b010, 32'h1357_9BDF,
                         4, 2, 32'h0, 3, 13'h1FFF));
        tbl.push_back(mk(15'h7FFF, 1, 32'h0F0F_0F0F, 4'h5, 1, 0, 3'b011, 32'h2468_ACE0,
                         2, 2, 32'h0, 1, 13'h1FFF));
        tbl.push_back(mk(15'h3FFF, 0, 32'h0, 4'hC, 1, 4, 3'b001, 32'h8000_0001,
                         6, 0, 32'h8000_0001, 5, 13'h1FFF));
        tbl.push_back(mk(15'h4000, 0, 32'h0, 4'hF, 1, 0, 3'b110, 32'h9999_9999,
                         2, 1, 32'h0, 1, 13'h0000));
`ifdef L1_INTERCON_TIMEOUT_EN
        tbl.push_back(mk(15'h2100, 0, 32'h0, 4'hF, 1, 0, 3'b000, 32'h4444_4444,
                         257, 1, 32'h0, 256, 13'h0100));
        tbl.push_back(mk(15'h5000, 0, 32'h0, 4'hF, 1, 255, 3'b001, 32'h7777_1234,
                         257, 0, 32'h7777_1234, 256, 13'h1000));
`endif

        // Reset state
        rst = 1'b1; ce = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        wb_adr = '0; wb_wdat = '0; wb_sel = '0;
        s_ack = '0; s_err = '0; s_rty = '0;
        for (int s = 0; s < 4; s++) s_rdat[s] = 32'hFFFF_0000 | 32'(s);
        tick();
        tick();
        check("reset_outputs_zero", out_nonzero(), 0);
        rst = 1'b0;
        tick();
        check("idle_after_reset", out_nonzero(), 0);

        for (int i = 0; i < tbl.size(); i++) begin
            run_xfer(tbl[i], r);
            check_xfer($sformatf("vec%0d", i), tbl[i], r);
        end

        for (int i = 0; i < 40; i++) begin
            v.adr   = 15'($urandom_range(0, 32767));
            v.we    = 1'($urandom);
            v.wdat  = $urandom;
            v.sel   = 4'($urandom);
            v.ce    = ($urandom_range(0, 4) != 0);
            v.dly   = int'($urandom_range(0, 6));
            v.mask  = 3'($urandom_range(1, 7));
            v.rdata = $urandom;
            v = model(v);
            run_xfer(v, r);
            check_xfer($sformatf("rnd%0d", i), v, r);
        end

        // Back-to-back: master holds cyc/stb through the ack and retargets.
        wb_adr = 15'h2008; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1; ce = 1'b1;
        s_rdat[1] = 32'h1111_2222; s_rdat[2] = 32'h3333_4444;
        tick();
        check("b2b_stb_a", ds_stb, 4'b0010);
        s_ack[1] = 1'b1;
        tick();
        s_ack[1] = 1'b0;
        check("b2b_ack_a", {wb_ack, wb_err, wb_rty}, 3'b100);
        check("b2b_dat_a", wb_rdat, 32'h1111_2222);
        wb_adr = 15'h4020;
        tick();
        check("b2b_gap", {wb_ack, ds_stb}, 5'b0);
        tick();
        check("b2b_stb_b", ds_stb, 4'b0100);
        check("b2b_adr_b", ds_adr[2], 13'h0020);
        s_ack[2] = 1'b1;
        tick();
        s_ack[2] = 1'b0;
        wb_cyc = 1'b0; wb_stb = 1'b0;
        check("b2b_ack_b", {wb_ack, wb_err, wb_rty}, 3'b100);
        check("b2b_dat_b", wb_rdat, 32'h3333_4444);
        tick();
        check("b2b_idle", {wb_ack, ds_stb}, 5'b0);

        // Upstream abort while the thresh slave stalls.
        wb_adr = 15'h0100; wb_cyc = 1'b1; wb_stb = 1'b1;
        tick();
        tick();
        check("abort_stb_before", ds_stb, 4'b0001);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        tick();
        check("abort_stb_dropped", {ds_cyc, ds_stb}, 8'h0);
        nr = int'(wb_ack || wb_err || wb_rty);
        for (int c = 0; c < 3; c++) begin
            tick();
            nr += int'(wb_ack || wb_err || wb_rty);
        end
        check("abort_no_response", nr, 0);

        // Reset mid-transaction with live downstream state.
        wb_adr = 15'h0040; wb_we = 1'b1; wb_wdat = 32'hDEAD_BEEF; wb_sel = 4'hF;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        tick();
        tick();
        check("rst_pre_stb", ds_stb, 4'b0001);
        rst = 1'b1;
        tick();
        check("rst_mid_outputs_zero", out_nonzero(), 0);
        rst = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
        tick();
        check("rst_after_release", out_nonzero(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
